// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data memory arbiter, its two requesters and dmem.
// The arbiter takes the slave view. The environment (core, external
// requester and dmem) takes the master view.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // core memory/writeback-stage access
    logic                  core_req;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic                  core_stall;

    // external requester (loader / debug DMA)
    logic                  ext_req;
    logic                  ext_we;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_wdata;
    logic                  ext_gnt;
    logic                  ext_rvalid;
    logic [DATA_WIDTH-1:0] ext_rdata;

    // single-port data memory
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_w_en;
    logic                  mem_read_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_addr, mem_wdata, mem_w_en, mem_read_en,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_addr, mem_wdata, mem_w_en, mem_read_en,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// The core normally wins and completes in its grant cycle. The external
// requester uses a req/gnt handshake with a registered read return. A
// starvation counter forces an external grant after STARVE_LIMIT contested
// cycles the core has won. That grant stalls the core for one cycle.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Access presented to the memory port by whichever side holds it.
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    logic [3:0]            starve_cnt;
    logic                  force_ext;
    logic                  ext_gnt;
    logic                  core_gnt;
    logic                  any_gnt;
    mem_req_t              sel;
    logic                  ext_rvalid_q;
    logic [DATA_WIDTH-1:0] ext_rdata_q;

    // Grant decision. reset low gates every grant, so no strobe escapes
    // while the block is held in reset.
    always_comb begin
        force_ext = bus.ext_req && (starve_cnt == LIMIT);
        ext_gnt   = reset && bus.ext_req && (!bus.core_req || force_ext);
        core_gnt  = reset && bus.core_req && !ext_gnt;
        any_gnt   = ext_gnt || core_gnt;
    end

    // Memory port mux. The core side is the idle default. Address and
    // data are don't-care without a grant, because both strobes are low.
    always_comb begin
        sel.we    = bus.core_we;
        sel.addr  = bus.core_addr;
        sel.wdata = bus.core_wdata;
        if (ext_gnt) begin
            sel.we    = bus.ext_we;
            sel.addr  = bus.ext_addr;
            sel.wdata = bus.ext_wdata;
        end
    end

    assign bus.mem_addr    = sel.addr;
    assign bus.mem_wdata   = sel.wdata;
    assign bus.mem_w_en    = any_gnt && sel.we;
    assign bus.mem_read_en = any_gnt && !sel.we;

    assign bus.ext_gnt     = ext_gnt;
    assign bus.core_stall  = reset && bus.core_req && !core_gnt;
    assign bus.core_rdata  = bus.mem_rdata;
    assign bus.ext_rvalid  = ext_rvalid_q;
    assign bus.ext_rdata   = ext_rdata_q;

    // Starvation counter. It counts the contested cycles the core has won
    // since the external request last went up or was served. It clears
    // on a grant or when the request drops (abort).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (ext_gnt || !bus.ext_req) begin
            starve_cnt <= '0;
        end else if (core_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // External read return, one cycle after the read grant. rdata holds
    // between returns. A reset during the return drops it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else if (ext_gnt && !bus.ext_we) begin
            ext_rvalid_q <= 1'b1;
            ext_rdata_q  <= bus.mem_rdata;
        end else begin
            ext_rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. It drives directed vectors, backs the memory
// port with a small word array, and compares the outputs every cycle
// against a request-level model. Literal expectations pin key scenarios.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // dmem stand-in: combinational read, write at the clock edge
    logic [31:0] dmem [0:255] = '{default: 32'h0};
    assign bus.mem_rdata = dmem[bus.mem_addr[9:2]];
    always @(posedge clk) if (bus.mem_w_en) dmem[bus.mem_addr[9:2]] <= bus.mem_wdata;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model contents of memory. It is updated only from the model's own
    // grant decisions.
    logic [31:0] ref_mem [0:255] = '{default: 32'h0};

    // Request-level model and per-cycle compare. m_wait counts the cycles
    // the external side has lost to the core while it kept requesting.
    initial begin
        int          m_wait;
        logic        m_rv;
        logic [31:0] m_rd;
        logic        e_ext, e_core, e_we;
        logic [31:0] e_addr, e_wd;
        m_wait = 0; m_rv = 1'b0; m_rd = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_wait = 0; m_rv = 1'b0; m_rd = 32'h0;
                chk("rst ext_gnt",    32'(bus.ext_gnt),     32'h0);
                chk("rst core_stall", 32'(bus.core_stall),  32'h0);
                chk("rst mem_w_en",   32'(bus.mem_w_en),    32'h0);
                chk("rst mem_read_en",32'(bus.mem_read_en), 32'h0);
                chk("rst ext_rvalid", 32'(bus.ext_rvalid),  32'h0);
                chk("rst ext_rdata",  bus.ext_rdata,        32'h0);
            end else begin
                e_ext  = bus.ext_req && (!bus.core_req || m_wait >= SL);
                e_core = bus.core_req && !e_ext;
                e_we   = e_ext ? bus.ext_we    : bus.core_we;
                e_addr = e_ext ? bus.ext_addr  : bus.core_addr;
                e_wd   = e_ext ? bus.ext_wdata : bus.core_wdata;
                chk("ext_gnt",     32'(bus.ext_gnt),     32'(e_ext));
                chk("core_stall",  32'(bus.core_stall),  32'(bus.core_req && !e_core));
                chk("mem_w_en",    32'(bus.mem_w_en),    32'((e_ext || e_core) && e_we));
                chk("mem_read_en", 32'(bus.mem_read_en), 32'((e_ext || e_core) && !e_we));
                chk("ext_rvalid",  32'(bus.ext_rvalid),  32'(m_rv));
                chk("ext_rdata",   bus.ext_rdata,        m_rd);
                if (e_ext || e_core) chk("mem_addr", bus.mem_addr, e_addr);
                if ((e_ext || e_core) && e_we) chk("mem_wdata", bus.mem_wdata, e_wd);
                if (e_core && !bus.core_we)
                    chk("core_rdata", bus.core_rdata, ref_mem[bus.core_addr[9:2]]);
                // state for the next cycle
                if (e_ext && !bus.ext_we) begin
                    m_rv = 1'b1;
                    m_rd = ref_mem[bus.ext_addr[9:2]];
                end else begin
                    m_rv = 1'b0;
                end
                if ((e_ext || e_core) && e_we) ref_mem[e_addr[9:2]] = e_wd;
                if (e_ext || !bus.ext_req) m_wait = 0;
                else if (e_core) m_wait++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus with hand-computed literal expectations
    initial begin
        logic [9:0]  pat, stl;
        logic [1:0]  early;
        logic [4:0]  late;
        logic [31:0] bdat [0:2];
        bdat[0] = 32'h11111111; bdat[1] = 32'h22222222; bdat[2] = 32'h33333333;
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wdata = 0;
        #1 reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();

        // core only: store, then load back
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 32'h10; bus.core_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1 store stall", 32'(bus.core_stall), 32'h0);
        chk("t1 store ext_gnt", 32'(bus.ext_gnt), 32'h0);
        tick();
        bus.core_we = 0;
        @(negedge clk);
        chk("t1 load data", bus.core_rdata, 32'hDEADBEEF);
        chk("t1 load stall", 32'(bus.core_stall), 32'h0);
        tick();
        bus.core_req = 0;

        // external only: write then read
        bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 32'h20; bus.ext_wdata = 32'h12345678;
        @(negedge clk);
        chk("t2 wr gnt", 32'(bus.ext_gnt), 32'h1);
        tick();
        bus.ext_we = 0;
        @(negedge clk);
        chk("t2 rd gnt", 32'(bus.ext_gnt), 32'h1);
        chk("t2 no rvalid for write", 32'(bus.ext_rvalid), 32'h0);
        tick();
        bus.ext_req = 0;
        @(negedge clk);
        chk("t2 rvalid", 32'(bus.ext_rvalid), 32'h1);
        chk("t2 rdata", bus.ext_rdata, 32'h12345678);
        tick();

        // continuous contention: core wins 4, external forced on the 5th
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 32'h10;
        bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 32'h40; bus.ext_wdata = 32'hA5A5A5A5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[i] = bus.ext_gnt;
            stl[i] = bus.core_stall;
            tick();
        end
        chk("t3 ext_gnt pattern", 32'(pat), 32'h210);
        chk("t3 stall pattern", 32'(stl), 32'h210);
        bus.ext_req = 0;

        // abort: 2 contested cycles, drop 1 cycle, then the count restarts
        tick();
        bus.ext_req = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); early[i] = bus.ext_gnt; tick();
        end
        bus.ext_req = 0;
        tick();
        bus.ext_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); late[i] = bus.ext_gnt; tick();
        end
        chk("t4 pre-abort gnt", 32'(early), 32'h0);
        chk("t4 post-abort gnt", 32'(late), 32'h10);
        bus.ext_req = 0; bus.core_req = 0;
        tick();

        // reset during the read return
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 32'h20;
        @(negedge clk);
        chk("t5 rd gnt", 32'(bus.ext_gnt), 32'h1);
        @(posedge clk);
        #2 reset = 1'b0; bus.ext_we = 1;
        #1;
        chk("t5 rvalid dropped", 32'(bus.ext_rvalid), 32'h0);
        chk("t5 rdata cleared", bus.ext_rdata, 32'h0);
        chk("t5 w_en gated", 32'(bus.mem_w_en), 32'h0);
        tick();
        reset = 1'b1;
        bus.ext_req = 0;
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 32'h10;
        @(negedge clk);
        chk("t5 core after rst stall", 32'(bus.core_stall), 32'h0);
        chk("t5 core after rst data", bus.core_rdata, 32'hDEADBEEF);
        tick();
        bus.core_req = 0;

        // back-to-back external reads in request order
        bus.ext_req = 1; bus.ext_we = 1;
        for (int i = 0; i < 3; i++) begin
            bus.ext_addr = 32'(i * 4); bus.ext_wdata = bdat[i];
            tick();
        end
        bus.ext_we = 0;
        for (int i = 0; i < 3; i++) begin
            bus.ext_addr = 32'(i * 4);
            @(negedge clk);
            chk("t6 gnt", 32'(bus.ext_gnt), 32'h1);
            if (i == 0) begin
                chk("t6 rvalid before", 32'(bus.ext_rvalid), 32'h0);
            end else begin
                chk("t6 rvalid", 32'(bus.ext_rvalid), 32'h1);
                chk("t6 rdata", bus.ext_rdata, bdat[i-1]);
            end
            tick();
        end
        bus.ext_req = 0;
        @(negedge clk);
        chk("t6 rvalid last", 32'(bus.ext_rvalid), 32'h1);
        chk("t6 rdata last", bus.ext_rdata, 32'h33333333);
        tick();
        @(negedge clk);
        chk("t6 rvalid end", 32'(bus.ext_rvalid), 32'h0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data memory. It shares `dmem` between the core's memory/writeback-stage access and an external requester (program loader / debug DMA). Core accesses complete in the same cycle when granted. External accesses use a req/gnt handshake with a registered read-return. A starvation counter guarantees external progress and stalls the core when the external requester takes the port.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, byte address width
- `STARVE_LIMIT`, 4, contested core-won cycles before the external requester is forced a grant (legal range 1..15)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `core_req`  in  1  core MW-stage memory access valid (load or store)
- `core_we`  in  1  1 = store, 0 = load
- `core_addr`  in  ADDR_WIDTH  core address
- `core_wdata`  in  DATA_WIDTH  core store data
- `core_rdata`  out  DATA_WIDTH  load data; combinational from `mem_rdata`
- `core_stall`  out  1  core request not served this cycle
- `ext_req`  in  1  external access request, held until granted
- `ext_we`  in  1  1 = write, 0 = read
- `ext_addr`  in  ADDR_WIDTH  external address
- `ext_wdata`  in  DATA_WIDTH  external write data
- `ext_gnt`  out  1  external access performed this cycle
- `ext_rvalid`  out  1  registered; `ext_rdata` valid
- `ext_rdata`  out  DATA_WIDTH  registered external read data
- `mem_addr`  out  ADDR_WIDTH  to dmem `addr`
- `mem_wdata`  out  DATA_WIDTH  to dmem `data_in`
- `mem_w_en`  out  1  to dmem `w_en`
- `mem_read_en`  out  1  to dmem `read_en`
- `mem_rdata`  in  DATA_WIDTH  from dmem `data_out` (combinational read)

## Operation
- Internal state:
  - `starve_cnt`, 4 bits.
  - `ext_rvalid` and `ext_rdata` registers.
- The grant is combinational each cycle from the requests and `starve_cnt`:
  - `force_ext = ext_req && (starve_cnt == STARVE_LIMIT)`.
  - `ext_gnt = ext_req && (!core_req || force_ext)`.
  - `core_gnt = core_req && !ext_gnt`.
  - `core_stall = core_req && !core_gnt`.
- Memory mux:
  - Granted requester drives `mem_addr` and `mem_wdata`.
  - `mem_w_en = gnt && we`; `mem_read_en = gnt && !we`.
  - With no grant: all mem strobes 0, `mem_addr`/`mem_wdata` = core values (don't-care).
- `starve_cnt` update, in priority order:
  1. 0 if `ext_gnt` or `!ext_req`.
  2. Otherwise increment if `core_gnt` (contested cycle), saturating at `STARVE_LIMIT`.
- External read return: on a cycle with `ext_gnt && !ext_we`, register `ext_rdata <= mem_rdata` and `ext_rvalid <= 1`. Otherwise `ext_rvalid <= 0` and `ext_rdata` holds.
- External handshake:
  - `ext_req`, `ext_we`, `ext_addr` and `ext_wdata` stay stable while `ext_req=1 && ext_gnt=0`.
  - After a grant the requester may keep `ext_req` high with a new request. Back-to-back grants are legal.
- Writes are acknowledged by `ext_gnt` alone; no `ext_rvalid` for writes.
- `core_rdata = mem_rdata` at all times. It is meaningful only when `core_gnt && !core_we`.
- The core must hold its MW stage (same request) while `core_stall=1`.

## Timing
- Reset (`reset=0`, asynchronous):
  - `starve_cnt=0`, `ext_rvalid=0`, `ext_rdata=0`.
  - All grants, `core_stall`, `mem_w_en` and `mem_read_en` are forced 0 while reset is low.
- Core access latency: 0 cycles. Load data and store commit happen in the grant cycle.
- External write latency: the write commits at the `clk` edge ending the `ext_gnt` cycle.
- External read latency: `ext_rvalid` asserts exactly 1 cycle after the `ext_gnt` cycle, for 1 cycle per granted read.
- Worst-case external wait under continuous core traffic: `STARVE_LIMIT` cycles, then granted. The core is stalled exactly 1 cycle per forced grant.
- Simultaneous requests:
  - Core wins unless `force_ext`.
  - After a forced grant `starve_cnt=0`, so the core wins the next contested cycle.
- Reset asserted mid-read (grant cycle or rvalid cycle): `ext_rvalid` drops immediately. The pending return is lost and the requester must reissue.
- `ext_req` dropping before grant is legal (abort): `starve_cnt` clears next edge.

## Test plan
- Core only: `core_req=1`, `core_we=1`, addr 0x10, data 0xDEADBEEF; next cycle load from 0x10 → `core_rdata=0xDEADBEEF`, `core_stall=0` both cycles, `ext_gnt=0`.
- External only: write 0x20←0x12345678, then read 0x20 → `ext_gnt=1` each cycle; `ext_rvalid=1` with `ext_rdata=0x12345678` one cycle after the read grant; never asserted for the write.
- Contention, `STARVE_LIMIT=4`: `core_req` and `ext_req` held high continuously → core granted 4 cycles, then `ext_gnt=1` with `core_stall=1` for 1 cycle; pattern repeats every 5 cycles; `starve_cnt` returns to 0 after each forced grant.
- Abort: `ext_req` high 2 contested cycles then low 1 cycle then high → counter restarts; ext granted only after 4 further contested cycles.
- Async reset mid-read: assert `reset=0` between the ext read grant edge and the next rising edge → `ext_rvalid=0` and `ext_rdata=0` immediately, `mem_w_en=0`; after release, a core request is granted with `core_stall=0`.
- Back-to-back external reads of 0x0, 0x4, 0x8 with core idle → three consecutive grants; `ext_rvalid` high for three consecutive cycles with data in request order.
